// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg
// Shared types and constants for the multi-cycle ALU (alu_seq).
//   alu_op_e : 3-bit ALUControl op codes
//   state_e  : controller states (IDLE, ITER, DONE)
//   FLAG_*   : bit positions inside the {N,Z,C,V} flag vector
// Optional feature macro: ALU_SEQ_DIV_EN (enables the iterative divider).
// ----------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_ORR  = 3'b011,
        OP_MOV  = 3'b100,
        OP_EOR  = 3'b101,
        OP_MUL  = 3'b110,
        OP_UDIV = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // True for the ops that run through the shift/accumulate engine.
    function automatic logic is_iter_op(alu_op_e op);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_MUL) || (op == OP_UDIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// ----------------------------------------------------------------------------
// alu_seq_if
// Operand/result bus of alu_seq with start/busy/done handshake.
//   start, ALUControl, A, B : controller -> ALU
//   busy, done, Result, ALUFlags : ALU -> controller
// master modport = controller side, slave modport = ALU side.
// ----------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int N = 32
);
    logic         start;
    logic [2:0]   ALUControl;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] Result;
    logic [3:0]   ALUFlags;

    modport master (
        output start, ALUControl, A, B,
        input  busy, done, Result, ALUFlags
    );

    modport slave (
        input  start, ALUControl, A, B,
        output busy, done, Result, ALUFlags
    );
endinterface

// File: rtl/alu_seq_iter.sv
// ----------------------------------------------------------------------------
// alu_seq_iter
// Shared shift register / accumulator for iterative unsigned MUL (shift-add)
// and unsigned UDIV (restoring). One step per cycle while step_i is high.
//   clk      : clock, rising edge
//   load_i   : capture operands and clear the accumulator
//   step_i   : perform one iteration
//   div_i    : 1 = divide, 0 = multiply (only meaningful with ALU_SEQ_DIV_EN)
//   a_i, b_i : operands (multiplicand/multiplier, dividend/divisor)
//   result_o : product (low N bits) or quotient as it will stand after the
//              current cycle's step, so the caller can register it on the
//              edge that completes the last iteration.
// Optional feature macro: ALU_SEQ_DIV_EN (divider datapath present).
// ----------------------------------------------------------------------------
module alu_seq_iter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         div_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] result_o
);

    // acc : MUL partial product / UDIV partial remainder
    // x   : MUL multiplier (shifts right) / UDIV dividend becoming quotient (shifts left)
    // y   : MUL multiplicand (shifts left) / UDIV divisor (static)
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] x_q, x_d;
    logic [N-1:0] y_q, y_d;

`ifdef ALU_SEQ_DIV_EN
    logic [N:0] trial_rem;
    logic [N:0] diff_rem;
`else
    logic unused_div;
    assign unused_div = div_i;
`endif

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
`ifdef ALU_SEQ_DIV_EN
        trial_rem = {acc_q, x_q[N-1]};
        diff_rem  = trial_rem - {1'b0, y_q};
`endif
        if (load_i) begin
            acc_d = '0;
            x_d   = a_i;
            y_d   = b_i;
        end else if (step_i) begin
`ifdef ALU_SEQ_DIV_EN
            if (div_i) begin
                // Shift next dividend bit into the remainder; subtract the
                // divisor if it fits and record a 1 in the quotient.
                x_d = {x_q[N-2:0], 1'b0};
                if (trial_rem >= {1'b0, y_q}) begin
                    acc_d  = diff_rem[N-1:0];
                    x_d[0] = 1'b1;
                end else begin
                    acc_d = trial_rem[N-1:0];
                end
            end else
`endif
            begin
                if (x_q[0]) begin
                    acc_d = acc_q + y_q;
                end
                x_d = x_q >> 1;
                y_d = y_q << 1;
            end
        end
    end

`ifdef ALU_SEQ_DIV_EN
    assign result_o = div_i ? x_d : acc_d;
`else
    assign result_o = acc_d;
`endif

    // NOTE: pure datapath registers carry no reset; they are always loaded
    // before any value derived from them is registered as a result.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        x_q   <= x_d;
        y_q   <= y_d;
    end

endmodule

// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq
// Multi-cycle ALU: single-cycle ADD/SUB/AND/ORR/MOV/EOR plus iterative
// unsigned MUL and (optionally) UDIV, with a start/busy/done handshake and
// registered {N,Z,C,V} flags.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; aborts any operation in progress
//   bus   : alu_seq_if slave modport
//           start/ALUControl/A/B in; busy/done/Result/ALUFlags out
// Single-cycle ops: done one cycle after the start edge.
// MUL/UDIV: busy for N cycles, done N+1 cycles after the start edge.
// Optional feature macro: ALU_SEQ_DIV_EN. Without it, code 111 completes in
// one cycle with Result=0 and flags 4'b0100.
// ----------------------------------------------------------------------------
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    alu_op_e op;
    assign op = alu_op_e'(bus.ALUControl);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          div_q, div_d;
    logic [N-1:0]  result_q, result_d;
    logic [3:0]    flags_q, flags_d;
    logic          done_q, done_d;
`ifdef ALU_SEQ_DIV_EN
    logic          bzero_q, bzero_d;
`endif

    logic          iter_load, iter_step;
    logic [N-1:0]  iter_result;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic          sub;
    logic [N:0]    sum;
    logic [N-1:0]  sc_result;
    logic          sc_c, sc_v;

    always_comb begin
        sub       = (op == OP_SUB);
        // SUB is A + ~B + 1, so the carry out is NOT borrow.
        sum       = {1'b0, bus.A} + {1'b0, (sub ? ~bus.B : bus.B)} + (N+1)'(sub);
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB: begin
                sc_result = sum[N-1:0];
                sc_c      = sum[N];
                sc_v      = ~(sub ^ bus.A[N-1] ^ bus.B[N-1]) & (bus.A[N-1] ^ sum[N-1]);
            end
            OP_AND:  sc_result = bus.A & bus.B;
            OP_ORR:  sc_result = bus.A | bus.B;
            OP_MOV:  sc_result = bus.B;
            OP_EOR:  sc_result = bus.A ^ bus.B;
            // MUL never reaches here; UDIV only does when the divider is
            // absent, and then completes with a zero result.
            default: sc_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iteration engine
    // ------------------------------------------------------------------
    alu_seq_iter #(.N(N)) u_iter (
        .clk      (clk),
        .load_i   (iter_load),
        .step_i   (iter_step),
        .div_i    (div_q),
        .a_i      (bus.A),
        .b_i      (bus.B),
        .result_o (iter_result)
    );

    // ------------------------------------------------------------------
    // Controller: next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        result_d  = result_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        iter_load = 1'b0;
        iter_step = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        bzero_d   = bzero_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    if (is_iter_op(op)) begin
                        iter_load = 1'b1;
                        div_d     = (op == OP_UDIV);
`ifdef ALU_SEQ_DIV_EN
                        bzero_d   = (bus.B == '0);
`endif
                        cnt_d     = CNT_LAST;
                        state_d   = ITER;
                    end else begin
                        result_d         = sc_result;
                        flags_d[FLAG_N]  = sc_result[N-1];
                        flags_d[FLAG_Z]  = (sc_result == '0);
                        flags_d[FLAG_C]  = sc_c;
                        flags_d[FLAG_V]  = sc_v;
                        done_d           = 1'b1;
                    end
                end
            end

            ITER: begin
                iter_step = 1'b1;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    // iter_result already reflects this final step.
                    result_d         = iter_result;
                    flags_d[FLAG_N]  = iter_result[N-1];
                    flags_d[FLAG_Z]  = (iter_result == '0);
                    flags_d[FLAG_C]  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
                    flags_d[FLAG_V]  = div_q & bzero_q;
`else
                    flags_d[FLAG_V]  = 1'b0;
`endif
                    done_d           = 1'b1;
                    state_d          = DONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            bzero_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
`ifdef ALU_SEQ_DIV_EN
            bzero_q  <= bzero_d;
`endif
        end
    end

    assign bus.busy     = (state_q == ITER);
    assign bus.done     = done_q;
    assign bus.Result   = result_q;
    assign bus.ALUFlags = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq at N=8: directed scenarios followed by
// randomized ops, each compared against an arithmetic reference model.
// Honors ALU_SEQ_DIV_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int N = 8;
`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_if #(.N(N)) bus ();

    alu_seq #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {flags[3:0], result[7:0]} from plain arithmetic.
    function automatic logic [11:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int          sa, sb, s;
        int unsigned u;
        logic [7:0]  r;
        logic        c, v;
        sa = $signed(a);
        sb = $signed(b);
        c  = 1'b0;
        v  = 1'b0;
        r  = 8'h00;
        case (op)
            3'd0: begin
                u = a + b;
                r = u[7:0];
                c = (u > 255);
                s = sa + sb;
                v = (s > 127) || (s < -128);
            end
            3'd1: begin
                u = a - b;
                r = u[7:0];
                c = (a >= b);
                s = sa - sb;
                v = (s > 127) || (s < -128);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = b;
            3'd5: r = a ^ b;
            3'd6: begin
                u = a * b;
                r = u[7:0];
            end
            default: begin
                if (DIV_EN) begin
                    if (b == 0) begin
                        r = 8'hFF;
                        v = 1'b1;
                    end else begin
                        r = a / b;
                    end
                end else begin
                    r = 8'h00;
                end
            end
        endcase
        return {r[7], (r == 8'h00), c, v, r};
    endfunction

    // Issue one op, follow it to completion and check timing and outputs.
    // inject: pulse an ADD start in the third cycle after the start edge.
    // hold:   return in the done cycle (so the next op starts back-to-back).
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input string tag, input bit inject, input bit hold);
        logic [11:0] exp;
        int          cycles, busy_cnt, lat;
        bit          iter;
        exp  = model(op, a, b);
        iter = (op == 3'd6) || (op == 3'd7 && DIV_EN);
        lat  = iter ? N + 1 : 1;

        @(negedge clk);
        bus.start      = 1'b1;
        bus.ALUControl = op;
        bus.A          = a;
        bus.B          = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = 8'($urandom);
        bus.B     = 8'($urandom);
        cycles    = 1;
        busy_cnt  = 0;
        while (!bus.done && cycles < 40) begin
            if (bus.busy) busy_cnt++;
            if (inject && cycles == 3) begin
                bus.start      = 1'b1;
                bus.ALUControl = 3'd0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.start = 1'b0;
        check({tag, " done"},    32'(bus.done),     32'd1);
        check({tag, " latency"}, 32'(cycles),       32'(lat));
        check({tag, " busycnt"}, 32'(busy_cnt),     32'(iter ? N : 0));
        check({tag, " busy@done"}, 32'(bus.busy),   32'd0);
        check({tag, " result"},  32'(bus.Result),   32'(exp[7:0]));
        check({tag, " flags"},   32'(bus.ALUFlags), 32'(exp[11:8]));
        if (!hold) begin
            @(posedge clk);
            #1;
            check({tag, " done1pulse"}, 32'(bus.done),     32'd0);
            check({tag, " hold"},       32'(bus.Result),   32'(exp[7:0]));
            check({tag, " holdflags"},  32'(bus.ALUFlags), 32'(exp[11:8]));
        end
    endtask

    initial begin
        int          done_seen;
        logic [2:0]  rop;
        logic [7:0]  ra, rb;

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.ALUControl = 3'd0;
        bus.A          = 8'h00;
        bus.B          = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   32'(bus.busy),     32'd0);
        check("reset done",   32'(bus.done),     32'd0);
        check("reset result", 32'(bus.Result),   32'd0);
        check("reset flags",  32'(bus.ALUFlags), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed ops
        run_op(3'd0, 8'h7F, 8'h01, "add_ovf",  1'b0, 1'b0);
        run_op(3'd1, 8'h05, 8'h05, "sub_zero", 1'b0, 1'b0);
        run_op(3'd2, 8'hF0, 8'h3C, "and",      1'b0, 1'b0);
        run_op(3'd6, 8'd13, 8'd11, "mul_inj",  1'b1, 1'b0);
        run_op(3'd7, 8'd200, 8'd7, "udiv",     1'b0, 1'b0);
        run_op(3'd7, 8'd5,  8'd0,  "udiv0",    1'b0, 1'b0);

        // Back-to-back: ADD started in the MUL's done cycle.
        run_op(3'd6, 8'd9,  8'd30, "mul_b2b",  1'b0, 1'b1);
        run_op(3'd0, 8'd3,  8'd4,  "add_b2b",  1'b0, 1'b0);

        // Result/flags hold while idle with changing inputs.
        repeat (5) begin
            @(negedge clk);
            bus.A          = 8'($urandom);
            bus.B          = 8'($urandom);
            bus.ALUControl = 3'($urandom);
        end
        #1;
        check("idle hold result", 32'(bus.Result),   32'h07);
        check("idle hold flags",  32'(bus.ALUFlags), 32'h0);

        // Reset during iteration 4 of a MUL.
        @(negedge clk);
        bus.start      = 1'b1;
        bus.ALUControl = 3'd6;
        bus.A          = 8'd13;
        bus.B          = 8'd11;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy",   32'(bus.busy),     32'd0);
        check("abort done",   32'(bus.done),     32'd0);
        check("abort result", 32'(bus.Result),   32'd0);
        check("abort flags",  32'(bus.ALUFlags), 32'd0);
        done_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        check("abort no done", 32'(done_seen), 32'd0);

        // Randomized ops, with occasional zero divisors and back-to-back starts.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            if (rop == 3'd7 && $urandom_range(0, 3) == 0) rb = 8'h00;
            run_op(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle, parametrised successor to the single-cycle datapath ALU.
- Adds iterative unsigned multiply (shift-add) and unsigned divide (restoring) alongside the existing ADD/SUB/AND/ORR/MOV ops.
- Uses a start/busy/done handshake and keeps the NZCV flag layout.
- Sits in the multi-cycle datapath; the controller stalls on busy.

Parameters:
- N, 32, operand/result width (≥4).
- CW, $clog2(N)+1, iteration counter width. Derived localparam; not overridable.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  accept op; sampled only when busy=0.
- ALUControl  input  3  op code: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV(B), 101 EOR, 110 MUL, 111 UDIV.
- A  input  N  operand A.
- B  input  N  operand B.
- busy  output  1  iterative op in progress.
- done  output  1  one-cycle pulse; Result/ALUFlags valid.
- Result  output  N  registered result; held until next completion.
- ALUFlags  output  4  registered {N,Z,C,V}; held with Result.

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, Result=0, ALUFlags=0.
  - Reset mid-operation aborts it; no done pulse.
- States:
  - IDLE: start=1 with a single-cycle op → result and flags registered at that edge; done=1 for the following cycle; stay IDLE.
  - IDLE: start=1 with MUL/UDIV → operands latched; go to ITER; busy=1.
  - ITER: exactly N iterations, counter N-1 down to 0. On the edge ending the last iteration, register Result/ALUFlags, then go to DONE; busy=0.
  - DONE: done=1 for one cycle, then IDLE. A start in DONE is accepted like IDLE, giving back-to-back ops.
- Latency: single-cycle ops take 1 cycle (start edge → done). MUL/UDIV take N+1 cycles from the start edge to the done cycle; busy is high for exactly N cycles.
- start while busy=1: ignored; latched operands are unaffected.
- done is never asserted in two consecutive cycles for one op.
- Arithmetic:
  - ADD/SUB: {C,Result} = A + (B or ~B) + sub.
  - V = ~(sub^A[N-1]^B[N-1]) & (A[N-1]^Result[N-1]).
  - SUB carry = NOT borrow.
- Logical, MOV and EOR: C=0, V=0.
- MUL: Result = low N bits of A*B (unsigned); C=0, V=0.
- UDIV: Result = floor(A/B); remainder is discarded. Divide by zero: Result = all ones, V=1, C=0.
- N = Result[N-1] and Z = (Result==0) for every op.

Optional Feature:
- Macro ALU_SEQ_DIV_EN.
- Defined: UDIV implemented as above.
- Undefined: divider logic absent. Code 111 completes in 1 cycle with Result=0 and ALUFlags=4'b0100; busy is never raised for it.

Decomposition:
- Package alu_seq_pkg holds:
  - alu_op_e enum of the 3-bit codes.
  - state_e {IDLE, ITER, DONE}.
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module alu_seq_iter holds the shared shift register/accumulator for MUL and UDIV. It takes load, step and op inputs and presents a product/quotient output. The top level owns the FSM, counter and flag logic.

Test Plan (N=8):
- ADD A=0x7F, B=0x01, start → next cycle done=1, Result=0x80, flags=1001 (N,V); busy stays 0.
- SUB A=0x05, B=0x05 → Result=0x00, flags=0110 (Z,C); then AND 0xF0&0x3C → 0x30, flags=0000.
- MUL A=13, B=11 → busy high 8 cycles; done on cycle 9 after start; Result=0x8F, flags=1000. A start pulse with ADD mid-operation is ignored.
- UDIV 200/7 → Result=0x1C, flags=0000. UDIV 5/0 → Result=0xFF, flags=1001. With the macro undefined: 1-cycle done, Result=0x00, flags=0100.
- Back-to-back: MUL completes, start ADD 3+4 in the DONE cycle → done on the next cycle with Result=0x07. Result/flags hold between ops.
- reset asserted at iteration 4 of a MUL → next cycle busy=0, done=0, Result=0, flags=0; no done pulse follows.
